// File: rtl/pool_stream.sv
// pool_stream: streaming 2x2 stride-2 pooling over raster-order packed pixels.
// Max pooling always; defining POOL_AVG_EN adds a pool_mode port selecting average pooling per frame.
module pool_stream #(
    parameter int IN_X       = 24,
    parameter int IN_Y       = 24,
    parameter int DATA_WIDTH = 45,
    parameter int CH         = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pool_enable,
`ifdef POOL_AVG_EN
    input  logic                     pool_mode,
`endif
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CH*DATA_WIDTH-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CH*DATA_WIDTH-1:0] out_data,
    output logic                     out_last,
    output logic                     pool_done
);
    localparam int CW = $clog2(IN_X);
    localparam int RW = $clog2(IN_Y);
    localparam int HX = IN_X / 2;
    localparam int IW = HX > 1 ? $clog2(HX) : 1;
`ifdef POOL_AVG_EN
    localparam int LW = DATA_WIDTH + 1;
`else
    localparam int LW = DATA_WIDTH;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                  state;
    logic [CW-1:0]           col;
    logic [RW-1:0]           row;
    logic [DATA_WIDTH-1:0]   hreg [CH];
    logic [LW-1:0]           lbuf [HX][CH];
    logic [LW-1:0]           pair [CH];
    logic [CH*DATA_WIDTH-1:0] win;
    logic [IW-1:0]           idx;
    logic                    accept, take, close, last_beat;
`ifdef POOL_AVG_EN
    logic                    avg;
`endif

    assign idx       = IW'(col >> 1);
    assign accept    = in_valid && in_ready;
    assign take      = out_valid && out_ready;
    assign last_beat = row == RW'(IN_Y - 1) && col == CW'(IN_X - 1);
    assign close     = accept && row[0] && col[0];
    assign in_ready  = state == RUN && (!out_valid || out_ready);

    // Per-channel horizontal pair value (to line buffer) and window result (to output register)
    for (genvar k = 0; k < CH; k++) begin : g_ch
        logic [DATA_WIDTH-1:0] x, hm, lm, wm;
        assign x  = in_data[k*DATA_WIDTH +: DATA_WIDTH];
        assign hm = hreg[k] > x ? hreg[k] : x;
        assign lm = lbuf[idx][k][DATA_WIDTH-1:0];
        assign wm = lm > hm ? lm : hm;
`ifdef POOL_AVG_EN
        logic [DATA_WIDTH+1:0] sum;
        assign sum = (DATA_WIDTH+2)'(lbuf[idx][k]) + (DATA_WIDTH+2)'(hreg[k]) + (DATA_WIDTH+2)'(x);
        assign pair[k] = avg ? LW'(hreg[k]) + LW'(x) : LW'(hm);
        assign win[k*DATA_WIDTH +: DATA_WIDTH] = avg ? DATA_WIDTH'(sum >> 2) : wm;
`else
        assign pair[k] = hm;
        assign win[k*DATA_WIDTH +: DATA_WIDTH] = wm;
`endif
    end

    // Horizontal register and half-width line buffer; their contents never need a reset
    always_ff @(posedge clk) begin
        if (accept && !col[0])
            for (int k = 0; k < CH; k++) hreg[k] <= in_data[k*DATA_WIDTH +: DATA_WIDTH];
        if (accept && !row[0] && col[0])
            lbuf[idx] <= pair;
    end

    // Frame sequencing, beat counters and the single-entry output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            pool_done <= 1'b0;
`ifdef POOL_AVG_EN
            avg       <= 1'b0;
`endif
        end else begin
            pool_done <= 1'b0;
            if (close) begin
                out_valid <= 1'b1;
                out_data  <= win;
                out_last  <= last_beat;
            end else if (take) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            if (accept) begin
                col <= col == CW'(IN_X - 1) ? '0 : col + 1'b1;
                row <= col == CW'(IN_X - 1) ? row + 1'b1 : row;
            end
            case (state)
                IDLE: if (pool_enable) begin
                    state <= RUN;
                    col   <= '0;
                    row   <= '0;
`ifdef POOL_AVG_EN
                    avg   <= pool_mode;
`endif
                end
                RUN: if (accept && last_beat) state <= DRAIN;
                DRAIN: if (!out_valid || take) begin
                    state     <= IDLE;
                    pool_done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
